// File: rtl/hpi_pkg.sv
// hpi_pkg
//   Shared definitions for the HPI target model: register offsets on the
//   two-bit hpi_address bus, bit positions inside the STATUS word, and a
//   helper that packs the STATUS word.
package hpi_pkg;

    // Register select values presented on hpi_address.
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // STATUS bit positions.
    localparam int STAT_RX_FULL = 0;  // host->device mailbox holds a word
    localparam int STAT_TX_FULL = 1;  // device->host mailbox holds a word
    localparam int STAT_OVR     = 2;  // host overwrote an unconsumed word

    // Pack the STATUS word: {13'b0, ovr, tx_full, rx_full}.
    function automatic logic [15:0] status_word(input logic ovr,
                                                input logic tx_full,
                                                input logic rx_full);
        logic [15:0] w;
        w = 16'h0000;
        w[STAT_OVR]     = ovr;
        w[STAT_TX_FULL] = tx_full;
        w[STAT_RX_FULL] = rx_full;
        return w;
    endfunction

endpackage

// File: rtl/hpi_ram.sv
// hpi_ram
//   Single-port 16-bit synchronous RAM with a registered read port, written
//   so that synthesis maps it onto block RAM. The read register only loads
//   when re is high, so rdata holds the last word read until the next read.
// Ports:
//   clk    - rising-edge clock
//   we     - write enable; wdata is stored at addr
//   re     - read enable; rdata loads mem[addr]
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data (not reset)
module hpi_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hpi_responder.sv
// hpi_responder
//   Target-side model of the OTG host-port interface. Decodes DATA, MAILBOX,
//   ADDRESS and STATUS, backs DATA with an auto-incrementing word RAM, and
//   provides a two-way mailbox to local device logic.
// Ports:
//   clk_clk, reset_reset          - clock, async active-high reset
//   hpi_address/cs_n/r_n/w_n      - initiator register select and strobes
//   hpi_data_in / hpi_data_out    - initiator write data / registered read data
//   mbx_rx_data/valid/ready       - host->device mailbox (DUT offers)
//   mbx_tx_data/valid/ready       - device->host mailbox (DUT accepts)
//   hpi_irq                       - device->host mailbox full, level
//
// Mailbox handshakes: a word moves across a device-side port on every rising
// edge where valid and ready are both high; valid never depends on ready.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic [15:0] mbx_rx_data,
    output logic        mbx_rx_valid,
    input  logic        mbx_rx_ready,
    input  logic [15:0] mbx_tx_data,
    input  logic        mbx_tx_valid,
    output logic        mbx_tx_ready,
    output logic        hpi_irq
);

    logic [15:0] addr_q;
    logic [15:0] rx_q;
    logic [15:0] tx_q;
    logic        rx_full;
    logic        tx_full;
    logic        ovr;

    // Access flag, stored as "armed": it goes high only after a cycle that is
    // not a valid access, and reset clears it. That way a strobe held low
    // through reset cannot fire until it has been released once.
    logic        arm_q;

    logic [15:0] rd_reg_q;    // read data for non-DATA registers
    logic        rd_ram_q;    // last read was DATA: output comes from the RAM
    logic [15:0] ram_rdata;

    logic access;
    logic start;
    logic wr_start;
    logic rd_start;
    logic is_data;
    logic is_mbx;
    logic is_addr;
    logic is_stat;
    logic tx_accept;
    logic rx_consume;

    // Exactly one strobe low; both low is not an access.
    assign access     = !hpi_cs_n && (hpi_r_n != hpi_w_n);
    assign start      = access && arm_q;
    assign wr_start   = start && !hpi_w_n;
    assign rd_start   = start && !hpi_r_n;

    assign is_data    = (hpi_address == HPI_DATA);
    assign is_mbx     = (hpi_address == HPI_MAILBOX);
    assign is_addr    = (hpi_address == HPI_ADDR);
    assign is_stat    = (hpi_address == HPI_STATUS);

    assign tx_accept  = mbx_tx_valid && !tx_full;
    assign rx_consume = mbx_rx_valid && mbx_rx_ready;

    assign mbx_rx_data  = rx_q;
    assign mbx_rx_valid = rx_full;
    assign mbx_tx_ready = !tx_full;
    assign hpi_irq      = tx_full;

    // Both sources are registers that only change on a read start.
    assign hpi_data_out = rd_ram_q ? ram_rdata : rd_reg_q;

    hpi_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_clk),
        .we    (wr_start && is_data),
        .re    (rd_start && is_data),
        .addr  (addr_q[AW:1]),
        .wdata (hpi_data_in),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            arm_q    <= 1'b0;
            addr_q   <= 16'h0000;
            rx_q     <= 16'h0000;
            tx_q     <= 16'h0000;
            rx_full  <= 1'b0;
            tx_full  <= 1'b0;
            ovr      <= 1'b0;
            rd_reg_q <= 16'h0000;
            rd_ram_q <= 1'b0;
        end else begin
            arm_q <= !access;

            // Address register: explicit load or post-increment on DATA.
            if (wr_start && is_addr) begin
                addr_q <= hpi_data_in;
            end else if (start && is_data) begin
                addr_q <= addr_q + 16'd2;
            end

            // Host->device mailbox. A host write in the same cycle as a
            // device consume wins and is not an overrun.
            if (wr_start && is_mbx) begin
                rx_q    <= hpi_data_in;
                rx_full <= 1'b1;
                if (rx_full && !rx_consume) begin
                    ovr <= 1'b1;
                end
            end else begin
                if (rx_consume) begin
                    rx_full <= 1'b0;
                end
                if (wr_start && is_stat && hpi_data_in[STAT_OVR]) begin
                    ovr <= 1'b0;
                end
            end

            // Device->host mailbox. When the host reads a full mailbox the
            // device sees ready low that cycle, so accept and clear never
            // collide on a full mailbox.
            if (tx_accept) begin
                tx_q    <= mbx_tx_data;
                tx_full <= 1'b1;
            end else if (rd_start && is_mbx) begin
                tx_full <= 1'b0;
            end

            // Read data capture.
            if (rd_start) begin
                rd_ram_q <= is_data;
                unique case (hpi_address)
                    HPI_MAILBOX: rd_reg_q <= tx_q;
                    HPI_ADDR:    rd_reg_q <= addr_q;
                    HPI_STATUS:  rd_reg_q <= status_word(ovr, tx_full, rx_full);
                    default:     rd_reg_q <= rd_reg_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder
//   Directed bench for hpi_responder: one task per feature, each with its
//   own inline checks against hand-computed values.
module tb_hpi_responder;
    import hpi_pkg::*;

    logic        clk_clk;
    logic        reset_reset;
    logic [1:0]  hpi_address;
    logic        hpi_cs_n;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic [15:0] mbx_rx_data;
    logic        mbx_rx_valid;
    logic        mbx_rx_ready;
    logic [15:0] mbx_tx_data;
    logic        mbx_tx_valid;
    logic        mbx_tx_ready;
    logic        hpi_irq;

    int tests_run = 0;
    int tests_failed = 0;

    hpi_responder #(
        .DEPTH (4096),
        .AW    (12)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .hpi_address  (hpi_address),
        .hpi_cs_n     (hpi_cs_n),
        .hpi_r_n      (hpi_r_n),
        .hpi_w_n      (hpi_w_n),
        .hpi_data_in  (hpi_data_in),
        .hpi_data_out (hpi_data_out),
        .mbx_rx_data  (mbx_rx_data),
        .mbx_rx_valid (mbx_rx_valid),
        .mbx_rx_ready (mbx_rx_ready),
        .mbx_tx_data  (mbx_tx_data),
        .mbx_tx_valid (mbx_tx_valid),
        .mbx_tx_ready (mbx_tx_ready),
        .hpi_irq      (hpi_irq)
    );

    // Clock / reset
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Driver tasks: called on a falling edge, return on a falling edge.
    task automatic hpi_write(input logic [1:0] a, input logic [15:0] d);
        hpi_address = a;
        hpi_data_in = d;
        hpi_cs_n    = 1'b0;
        hpi_w_n     = 1'b0;
        @(negedge clk_clk);
        hpi_w_n  = 1'b1;
        hpi_cs_n = 1'b1;
        @(negedge clk_clk);
    endtask

    task automatic hpi_read(input logic [1:0] a, output logic [15:0] d);
        hpi_address = a;
        hpi_cs_n    = 1'b0;
        hpi_r_n     = 1'b0;
        @(negedge clk_clk);
        d = hpi_data_out;
        hpi_r_n  = 1'b1;
        hpi_cs_n = 1'b1;
        @(negedge clk_clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset_reset = 1'b1;
        repeat (2) @(negedge clk_clk);
        tests_run++;
        if (hpi_data_out !== 16'h0000 || mbx_rx_valid !== 1'b0 || hpi_irq !== 1'b0
            || mbx_tx_ready !== 1'b1 || mbx_rx_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: data_out=%h rx_valid=%b irq=%b tx_ready=%b rx_data=%h",
                     hpi_data_out, mbx_rx_valid, hpi_irq, mbx_tx_ready, mbx_rx_data);
        end
        reset_reset = 1'b0;
        @(negedge clk_clk);
        hpi_read(HPI_STATUS, d);
        tests_run++;
        if (d !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_status: got %h want 0000", d);
        end
        hpi_read(HPI_ADDR, d);
        tests_run++;
        if (d !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h want 0000", d);
        end
    endtask

    task automatic test_auto_increment();
        logic [15:0] d;
        hpi_write(HPI_ADDR, 16'h1000);
        hpi_write(HPI_DATA, 16'hAAAA);
        hpi_write(HPI_DATA, 16'h5555);
        hpi_write(HPI_ADDR, 16'h1000);
        hpi_read(HPI_DATA, d);
        tests_run++;
        if (d !== 16'hAAAA) begin
            tests_failed++;
            $display("FAIL autoinc_rd0: got %h want aaaa", d);
        end
        hpi_read(HPI_DATA, d);
        tests_run++;
        if (d !== 16'h5555) begin
            tests_failed++;
            $display("FAIL autoinc_rd1: got %h want 5555", d);
        end
        // Read data must hold across idle cycles.
        repeat (3) @(negedge clk_clk);
        tests_run++;
        if (hpi_data_out !== 16'h5555) begin
            tests_failed++;
            $display("FAIL autoinc_hold: got %h want 5555", hpi_data_out);
        end
        hpi_read(HPI_ADDR, d);
        tests_run++;
        if (d !== 16'h1004) begin
            tests_failed++;
            $display("FAIL autoinc_addr: got %h want 1004", d);
        end
    endtask

    task automatic test_held_strobe();
        logic [15:0] d;
        hpi_write(HPI_ADDR, 16'h0202);
        hpi_write(HPI_DATA, 16'h7777);
        hpi_write(HPI_ADDR, 16'h0200);
        // w_n low for 5 cycles; data changes every cycle so a re-fire shows.
        hpi_address = HPI_DATA;
        hpi_cs_n    = 1'b0;
        hpi_w_n     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hpi_data_in = 16'h1111 * 16'(i + 1);
            @(negedge clk_clk);
        end
        hpi_w_n  = 1'b1;
        hpi_cs_n = 1'b1;
        @(negedge clk_clk);
        hpi_read(HPI_ADDR, d);
        tests_run++;
        if (d !== 16'h0202) begin
            tests_failed++;
            $display("FAIL held_addr: got %h want 0202", d);
        end
        hpi_write(HPI_ADDR, 16'h0200);
        hpi_read(HPI_DATA, d);
        tests_run++;
        if (d !== 16'h1111) begin
            tests_failed++;
            $display("FAIL held_word0: got %h want 1111", d);
        end
        hpi_read(HPI_DATA, d);
        tests_run++;
        if (d !== 16'h7777) begin
            tests_failed++;
            $display("FAIL held_word1: got %h want 7777", d);
        end
    endtask

    task automatic test_both_strobes();
        logic [15:0] d;
        hpi_write(HPI_ADDR, 16'h0400);
        hpi_address = HPI_ADDR;
        hpi_data_in = 16'h5A5A;
        hpi_cs_n    = 1'b0;
        hpi_w_n     = 1'b0;
        hpi_r_n     = 1'b0;
        repeat (2) @(negedge clk_clk);
        hpi_w_n  = 1'b1;
        hpi_r_n  = 1'b1;
        hpi_cs_n = 1'b1;
        @(negedge clk_clk);
        hpi_read(HPI_ADDR, d);
        tests_run++;
        if (d !== 16'h0400) begin
            tests_failed++;
            $display("FAIL both_strobes_addr: got %h want 0400", d);
        end
    endtask

    task automatic test_rx_mailbox();
        logic [15:0] d;
        mbx_rx_ready = 1'b0;
        hpi_write(HPI_MAILBOX, 16'h1234);
        tests_run++;
        if (mbx_rx_valid !== 1'b1 || mbx_rx_data !== 16'h1234) begin
            tests_failed++;
            $display("FAIL rx_first: valid=%b data=%h want 1/1234", mbx_rx_valid, mbx_rx_data);
        end
        hpi_write(HPI_MAILBOX, 16'h5678);
        hpi_read(HPI_STATUS, d);
        tests_run++;
        if (d !== 16'h0005 || mbx_rx_data !== 16'h5678) begin
            tests_failed++;
            $display("FAIL rx_overrun: status=%h data=%h want 0005/5678", d, mbx_rx_data);
        end
        hpi_write(HPI_STATUS, 16'h0004);
        hpi_read(HPI_STATUS, d);
        tests_run++;
        if (d !== 16'h0001) begin
            tests_failed++;
            $display("FAIL rx_ovr_clear: got %h want 0001", d);
        end
        // Device consumes the word.
        mbx_rx_ready = 1'b1;
        @(negedge clk_clk);
        mbx_rx_ready = 1'b0;
        tests_run++;
        if (mbx_rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_consume: valid=%b want 0", mbx_rx_valid);
        end
        // Host write colliding with a device consume: write wins, no overrun.
        hpi_write(HPI_MAILBOX, 16'hAAAA);
        hpi_address  = HPI_MAILBOX;
        hpi_data_in  = 16'hBBBB;
        hpi_cs_n     = 1'b0;
        hpi_w_n      = 1'b0;
        mbx_rx_ready = 1'b1;
        @(negedge clk_clk);
        mbx_rx_ready = 1'b0;
        hpi_w_n      = 1'b1;
        hpi_cs_n     = 1'b1;
        @(negedge clk_clk);
        hpi_read(HPI_STATUS, d);
        tests_run++;
        if (d !== 16'h0001 || mbx_rx_data !== 16'hBBBB) begin
            tests_failed++;
            $display("FAIL rx_collide: status=%h data=%h want 0001/bbbb", d, mbx_rx_data);
        end
        mbx_rx_ready = 1'b1;
        @(negedge clk_clk);
        mbx_rx_ready = 1'b0;
    endtask

    task automatic test_tx_mailbox();
        logic [15:0] d;
        mbx_tx_data  = 16'hBEEF;
        mbx_tx_valid = 1'b1;
        @(negedge clk_clk);
        mbx_tx_valid = 1'b0;
        tests_run++;
        if (hpi_irq !== 1'b1 || mbx_tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL tx_offer: irq=%b tx_ready=%b want 1/0", hpi_irq, mbx_tx_ready);
        end
        hpi_read(HPI_STATUS, d);
        tests_run++;
        if (d !== 16'h0002) begin
            tests_failed++;
            $display("FAIL tx_status: got %h want 0002", d);
        end
        hpi_read(HPI_MAILBOX, d);
        tests_run++;
        if (d !== 16'hBEEF || hpi_irq !== 1'b0 || mbx_tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_read: data=%h irq=%b tx_ready=%b want beef/0/1", d, hpi_irq, mbx_tx_ready);
        end
        // Refill, then host read while the device offers the next word: the
        // offer is refused during the read and taken on the following edge.
        mbx_tx_data  = 16'hC0DE;
        mbx_tx_valid = 1'b1;
        @(negedge clk_clk);
        mbx_tx_data  = 16'hF00D;
        hpi_read(HPI_MAILBOX, d);
        mbx_tx_valid = 1'b0;
        tests_run++;
        if (d !== 16'hC0DE || hpi_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_collide: data=%h irq=%b want c0de/1", d, hpi_irq);
        end
        hpi_read(HPI_MAILBOX, d);
        tests_run++;
        if (d !== 16'hF00D) begin
            tests_failed++;
            $display("FAIL tx_second: got %h want f00d", d);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] d;
        hpi_write(HPI_ADDR, 16'h0000);
        hpi_write(HPI_DATA, 16'h9999);
        hpi_write(HPI_ADDR, 16'h0000);
        // Leave tx mailbox full so reset has something to clear.
        mbx_tx_data  = 16'h1357;
        mbx_tx_valid = 1'b1;
        @(negedge clk_clk);
        mbx_tx_valid = 1'b0;
        hpi_address = HPI_DATA;
        hpi_cs_n    = 1'b0;
        hpi_r_n     = 1'b0;
        @(negedge clk_clk);
        reset_reset = 1'b1;
        #1;
        tests_run++;
        if (hpi_data_out !== 16'h0000 || hpi_irq !== 1'b0 || mbx_rx_valid !== 1'b0
            || mbx_rx_data !== 16'h0000 || mbx_tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_outputs: data_out=%h irq=%b rx_valid=%b rx_data=%h tx_ready=%b",
                     hpi_data_out, hpi_irq, mbx_rx_valid, mbx_rx_data, mbx_tx_ready);
        end
        @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (3) @(negedge clk_clk);
        tests_run++;
        if (hpi_data_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midrst_no_retrigger: data_out=%h want 0000", hpi_data_out);
        end
        hpi_r_n  = 1'b1;
        hpi_cs_n = 1'b1;
        @(negedge clk_clk);
        hpi_read(HPI_ADDR, d);
        tests_run++;
        if (d !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midrst_addr: got %h want 0000", d);
        end
        hpi_read(HPI_DATA, d);
        tests_run++;
        if (d !== 16'h9999) begin
            tests_failed++;
            $display("FAIL midrst_rearm: got %h want 9999", d);
        end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] d;
        hpi_write(HPI_ADDR, 16'hFFFE);
        hpi_write(HPI_DATA, 16'h4242);
        hpi_read(HPI_ADDR, d);
        tests_run++;
        if (d !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap_addr: got %h want 0000", d);
        end
        // 0xFFFE and 0x1FFE both map to word index 0xFFF.
        hpi_write(HPI_ADDR, 16'h1FFE);
        hpi_read(HPI_DATA, d);
        tests_run++;
        if (d !== 16'h4242) begin
            tests_failed++;
            $display("FAIL wrap_alias: got %h want 4242", d);
        end
    endtask

    initial begin
        reset_reset  = 1'b1;
        hpi_address  = 2'd0;
        hpi_cs_n     = 1'b1;
        hpi_r_n      = 1'b1;
        hpi_w_n      = 1'b1;
        hpi_data_in  = 16'h0000;
        mbx_rx_ready = 1'b0;
        mbx_tx_data  = 16'h0000;
        mbx_tx_valid = 1'b0;
        @(negedge clk_clk);

        test_reset();
        test_auto_increment();
        test_held_strobe();
        test_both_strobes();
        test_rx_mailbox();
        test_tx_mailbox();
        test_reset_mid_access();
        test_addr_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hpi_responder.md
# hpi_responder

Target-side model of the OTG host-port interface (HPI) driven by the SoC's `otg_hpi_*` PIO exports. It decodes the four HPI registers (DATA, MAILBOX, ADDRESS, STATUS) and backs DATA with an internal auto-incrementing word RAM. It also exposes a two-way mailbox to local device logic. It sits on the FPGA in place of the external USB controller, for self-test and for firmware bring-up without the chip.

## Interface
- `DEPTH`, 4096: RAM words of 16 bits; power of two.
- `AW`, 12: log2(DEPTH).
- `clk_clk` in 1: system clock; all logic is on its rising edge.
- `reset_reset` in 1: asynchronous, active-high reset.
- `hpi_address` in 2: register select. 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- `hpi_cs_n` in 1: chip select, active low.
- `hpi_r_n` in 1: read strobe, active low.
- `hpi_w_n` in 1: write strobe, active low.
- `hpi_data_in` in 16: write data from the initiator.
- `hpi_data_out` out 16: registered read data to the initiator.
- `mbx_rx_data` out 16: host→device mailbox word.
- `mbx_rx_valid` out 1: host→device mailbox is full.
- `mbx_rx_ready` in 1: device consumes the mailbox word.
- `mbx_tx_data` in 16: device→host mailbox word.
- `mbx_tx_valid` in 1: device offers a word.
- `mbx_tx_ready` out 1: device→host mailbox is empty.
- `hpi_irq` out 1: device→host mailbox is full, level.

## Operation
- Access start: the first cycle with `cs_n=0` and exactly one strobe low, where the previous cycle did not meet that condition. Detect it with a single registered "active" flag.
- One access start produces exactly one operation. Holding the strobes low does nothing further.
- If both strobes are low, the cycle is ignored and no state changes.
- Write on access start:
  - ADDRESS: `addr_q <= data_in` (byte address).
  - DATA: `ram[addr_q[AW:1]] <= data_in`, then `addr_q <= addr_q+2`.
  - MAILBOX: `rx_q <= data_in` and `rx_full <= 1`. If `rx_full` was already set, also set `ovr <= 1`.
  - STATUS: writing 1 to bit 2 clears `ovr`. All other bits are ignored.
- Read on access start:
  - DATA: returns `ram[addr_q[AW:1]]`, then `addr_q <= addr_q+2`.
  - ADDRESS: returns `addr_q`.
  - MAILBOX: returns `tx_q` and clears `tx_full`.
  - STATUS: returns `{13'b0, ovr, tx_full, rx_full}`.
- `addr_q` is 16 bits and wraps at 0xFFFF→0x0000. The RAM index ignores bit 0 and bits above AW, so the RAM aliases.
- Device side:
  - `mbx_rx_valid = rx_full`. When `mbx_rx_valid & mbx_rx_ready`, clear `rx_full`.
  - `mbx_tx_ready = !tx_full`. When `mbx_tx_valid & mbx_tx_ready`, `tx_q <= mbx_tx_data` and `tx_full <= 1`.
- Simultaneous events:
  - Host MAILBOX write in the same cycle as a device rx consume: the write wins, `rx_full=1`, and `ovr` is not set.
  - Host MAILBOX read in the same cycle as a device tx offer: `tx_ready` was 0, so no accept occurs. The offer is accepted the next cycle.
- Reset clears `addr_q`, `rx_q`, `tx_q`, `rx_full`, `tx_full`, `ovr`, the active flag and `hpi_data_out` to 0. RAM contents are not reset.
- A reset that lands mid-access aborts the access. The held strobes are not re-triggered until they deassert.

## Timing
- Write latency: register or RAM is updated at the edge that ends the access-start cycle.
- Read latency: `hpi_data_out` is valid one edge after access start and holds until the next read start.
- `hpi_irq` and `mbx_*` outputs are registered state, valid the cycle after any change.
- Strobes are synchronous to `clk_clk`; no synchronizers.
- The initiator must present address and data at or before strobe assertion.
- Minimum access length is one cycle low plus one cycle high.

## Structure
- Put register offsets (`HPI_DATA`, `HPI_MAILBOX`, `HPI_ADDR`, `HPI_STATUS`) and STATUS bit positions in a shared `hpi_pkg`.
- Use one sub-module, `hpi_ram`: single-port 16-bit synchronous RAM with registered read, inferred as block RAM.
- Decode, the address register and the mailbox logic stay in the top level.

## Test plan
- Address auto-increment: write ADDRESS=0x1000, write DATA 0xAAAA then 0x5555, write ADDRESS=0x1000, read DATA twice. Required: 0xAAAA, then 0x5555; final ADDRESS read is 0x1004.
- Held strobe: keep `w_n` low for 5 cycles on a DATA write. Required: one RAM write and `addr_q` advances by exactly 2.
- Host→device mailbox: host writes MAILBOX=0x1234. Required: `mbx_rx_valid=1` with data 0x1234 next cycle. A second write of 0x5678 before `ready` gives STATUS=0x0005; writing STATUS=0x0004 then gives 0x0001.
- Device→host mailbox: device offers 0xBEEF. Required: `hpi_irq=1` and STATUS bit1=1. A host MAILBOX read returns 0xBEEF, after which `irq=0` and `tx_ready=1`.
- Reset mid-access: assert `reset_reset` with `r_n` held low. Required: all outputs 0, and no read fires until the strobe goes high and low again.
- Address wrap: ADDRESS=0xFFFE, then a DATA write. Required: ADDRESS reads 0x0000 afterwards.
